// File: rtl/jk_cmd_seq.sv
// Command sequencer feeding a JK flop: queues {J,K} ops, replays each for len+1 cycles,
// and tracks the flop's expected Q. Registered J/K/drv_valid/cmd_last; cmd_ready drops when the FIFO is full.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     J,
  output logic                     K,
  output logic                     drv_valid,
  output logic                     cmd_last,
  output logic                     q_model,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  logic [1:0]       r_op_mem  [DEPTH];
  logic [LEN_W-1:0] r_len_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  logic             r_j;
  logic             r_k;
  logic             r_drv;
  logic             r_last;
  logic             r_q;
  logic [LEN_W-1:0] r_rem;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [1:0]       w_head_op;
  logic [LEN_W-1:0] w_head_len;

  state_t           w_nxt_state;
  logic             w_nxt_j;
  logic             w_nxt_k;
  logic             w_nxt_drv;
  logic             w_nxt_last;
  logic [LEN_W-1:0] w_nxt_rem;

  assign cmd_ready  = !rst && (r_count != FULL_CNT);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_empty    = (r_count == '0);
  assign w_head_op  = r_op_mem[r_rd_ptr];
  assign w_head_len = r_len_mem[r_rd_ptr];

  assign J          = r_j;
  assign K          = r_k;
  assign drv_valid  = r_drv;
  assign cmd_last   = r_last;
  assign q_model    = r_q;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]  <= cmd_op;
      r_len_mem[r_wr_ptr] <= cmd_len;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_j     = r_j;
    w_nxt_k     = r_k;
    w_nxt_drv   = r_drv;
    w_nxt_last  = 1'b0;
    w_nxt_rem   = r_rem;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_nxt_j   = 1'b0;
        w_nxt_k   = 1'b0;
        w_nxt_drv = 1'b0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_j     = w_head_op[1];
          w_nxt_k     = w_head_op[0];
          w_nxt_rem   = w_head_len;
          w_nxt_drv   = 1'b1;
          w_nxt_last  = (w_head_len == '0);
          w_nxt_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_rem != '0) begin
          w_nxt_rem  = r_rem - LEN_W'(1);
          w_nxt_last = (r_rem == LEN_W'(1));
        end else if (!w_empty) begin
          // Back-to-back command: load straight from the head, no idle cycle.
          w_pop      = 1'b1;
          w_nxt_j    = w_head_op[1];
          w_nxt_k    = w_head_op[0];
          w_nxt_rem  = w_head_len;
          w_nxt_drv  = 1'b1;
          w_nxt_last = (w_head_len == '0);
        end else begin
          w_nxt_j     = 1'b0;
          w_nxt_k     = 1'b0;
          w_nxt_drv   = 1'b0;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_drv   <= 1'b0;
      r_last  <= 1'b0;
      r_rem   <= '0;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_j     <= w_nxt_j;
      r_k     <= w_nxt_k;
      r_drv   <= w_nxt_drv;
      r_last  <= w_nxt_last;
      r_rem   <= w_nxt_rem;
      // Mirrors the downstream flop, which sees the same registered J/K.
      case ({r_j, r_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: queue-based reference model checked every cycle, plus directed trace checks.
module tb_jk_cmd_seq;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  localparam logic [2:0] E2 [4]  = '{3'b110, 3'b110, 3'b110, 3'b111};
  localparam logic       Q2 [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0] E4 [6]  = '{3'b010, 3'b011, 3'b100, 3'b100, 3'b101, 3'b001};
  localparam logic       Q4 [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready, J, K, drv_valid, cmd_last, q_model;
  logic [2:0]       fifo_count;

  int checks = 0;
  int failures = 0;

  jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .J(J), .K(K), .drv_valid(drv_valid),
    .cmd_last(cmd_last), .q_model(q_model), .fifo_count(fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream JK flop sharing clk/rst.
  logic q_ff;
  always @(posedge clk) begin
    if (rst) q_ff <= 1'b0;
    else case ({J, K})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  // Reference model: a queue of pending commands and the active one with cycles left to drive.
  typedef struct packed { logic [1:0] op; logic [LEN_W-1:0] len; } cmd_t;
  cmd_t m_fifo[$];
  bit   m_busy = 0;
  logic [1:0] m_op = 2'b00;
  int   m_left = 0;
  bit   m_qv = 0;
  bit   m_can_push;
  cmd_t m_c;
  bit   cmp_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_fifo.delete();
      m_busy = 0;
      m_left = 0;
      m_qv   = 0;
    end else begin
      m_can_push = (m_fifo.size() != DEPTH);
      if (m_busy) begin
        if (m_op == 2'b01) m_qv = 0;
        else if (m_op == 2'b10) m_qv = 1;
        else if (m_op == 2'b11) m_qv = !m_qv;
      end
      if (m_busy && m_left > 1) m_left--;
      else if (m_fifo.size() > 0) begin
        m_c    = m_fifo.pop_front();
        m_op   = m_c.op;
        m_left = int'(m_c.len) + 1;
        m_busy = 1;
      end else m_busy = 0;
      if (cmd_valid && m_can_push) m_fifo.push_back({cmd_op, cmd_len});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("J", J, m_busy & m_op[1]);
      check("K", K, m_busy & m_op[0]);
      check("drv_valid", drv_valid, m_busy);
      check("cmd_last", cmd_last, m_busy && m_left == 1);
      check("q_model", q_model, m_qv);
      check("fifo_count", fifo_count, m_fifo.size());
      check("cmd_ready", cmd_ready, !rst && m_fifo.size() != DEPTH);
      check("q_vs_flop", q_model, q_ff);
    end
  end

  // Trace of drive cycles {J,K,cmd_last}, and q_model in the cycle after each drive cycle.
  logic [2:0] tr_jkl[$];
  logic       tr_q[$];
  int         falls = 0;
  logic       prev_drv = 1'b0;
  always @(negedge clk) begin
    if (prev_drv === 1'b1) tr_q.push_back(q_model);
    if (drv_valid === 1'b1) tr_jkl.push_back({J, K, cmd_last});
    if (prev_drv === 1'b1 && drv_valid === 1'b0) falls++;
    prev_drv = drv_valid;
  end

  task automatic clear_trace();
    tr_jkl.delete();
    tr_q.delete();
    falls = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_trace();
  endtask

  task automatic push(input logic [1:0] op, input logic [LEN_W-1:0] len);
    bit acc = 0;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (cmd_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (drv_valid === 1'b0 && fifo_count === 3'd0) done = 1;
      n++;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  function automatic int count_last();
    int c = 0;
    foreach (tr_jkl[i]) if (tr_jkl[i][0]) c++;
    return c;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    check("rst_J", J, 0);
    check("rst_drv", drv_valid, 0);
    check("rst_last", cmd_last, 0);
    check("rst_q", q_model, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_trace();

    // Single set command, len 0.
    push(2'b10, 4'd0);
    wait_idle();
    check("t1_len", tr_jkl.size(), 1);
    check("t1_jkl", tr_jkl[0], 3'b101);
    check("t1_q_after", q_model, 1);
    check("t1_J_after", J, 0);

    // Toggle for 4 cycles from q=0.
    do_reset();
    push(2'b11, 4'd3);
    wait_idle();
    check("t2_len", tr_jkl.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_jkl%0d", i), tr_jkl[i], E2[i]);
      check($sformatf("t2_q%0d", i), tr_q[i], Q2[i]);
    end

    // Fill the FIFO while busy, then a fifth command that must wait for a pop.
    do_reset();
    push(2'b10, 4'd7);
    push(2'b01, 4'd1);
    push(2'b10, 4'd1);
    push(2'b11, 4'd1);
    push(2'b00, 4'd1);
    @(negedge clk);
    check("t3_full_count", fifo_count, 4);
    check("t3_full_ready", cmd_ready, 0);
    push(2'b10, 4'd0);
    wait_idle();
    check("t3_len", tr_jkl.size(), 17);
    check("t3_gaps", falls, 1);
    check("t3_jkl7", tr_jkl[7], 3'b101);
    check("t3_jkl8", tr_jkl[8], 3'b010);
    check("t3_jkl9", tr_jkl[9], 3'b011);
    check("t3_jkl14", tr_jkl[14], 3'b000);
    check("t3_jkl15", tr_jkl[15], 3'b001);
    check("t3_jkl16", tr_jkl[16], 3'b101);

    // Mixed sequence.
    do_reset();
    push(2'b01, 4'd1);
    push(2'b10, 4'd2);
    push(2'b00, 4'd0);
    wait_idle();
    check("t4_len", tr_jkl.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_jkl%0d", i), tr_jkl[i], E4[i]);
      check($sformatf("t4_q%0d", i), tr_q[i], Q4[i]);
    end

    // Reset in the 6th drive cycle of a long toggle.
    do_reset();
    push(2'b11, 4'd15);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("t5_ready_in_rst", cmd_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_drv", drv_valid, 0);
    check("t5_J", J, 0);
    check("t5_K", K, 0);
    check("t5_count", fifo_count, 0);
    check("t5_q", q_model, 0);
    check("t5_trace_len", tr_jkl.size(), 6);
    check("t5_no_last", count_last(), 0);

    // Maximum length.
    do_reset();
    push(2'b10, 4'd15);
    wait_idle();
    check("t6_len", tr_jkl.size(), 16);
    check("t6_jkl14", tr_jkl[14], 3'b100);
    check("t6_jkl15", tr_jkl[15], 3'b101);
    check("t6_lasts", count_last(), 1);
    check("t6_drv_after", drv_valid, 0);
    check("t6_q_after", q_model, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_cmd_seq.md
Name: jk_cmd_seq

Overview:
- Upstream stimulus stage for the JK flip-flop (ports clk, rst, J, K, Q, Q_bar).
- Accepts JK operation commands over a valid/ready interface and buffers them in a small FIFO.
- Replays each command onto J/K for a programmed number of clock cycles.
- Keeps a reference model of the downstream flop's Q so Q can be self-checked against it.

Parameters:
- DEPTH, 4: command FIFO entries; must be a power of 2, minimum 2.
- LEN_W, 4: width of cmd_len. Each command drives for cmd_len+1 cycles, giving a range of 1..2^LEN_W.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command present on cmd_op/cmd_len.
- cmd_ready, output, 1: FIFO can accept a command.
- cmd_op, input, 2: {J,K} to drive. 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_len, input, LEN_W: drive cycles minus one.
- J, output, 1: to the JK flop J input.
- K, output, 1: to the JK flop K input.
- drv_valid, output, 1: a command is currently being driven on J/K.
- cmd_last, output, 1: high in the final drive cycle of each command.
- q_model, output, 1: expected Q of the downstream JK flop.
- fifo_count, output, $clog2(DEPTH)+1: number of queued, not-yet-started commands.

Behaviour:
- Reset, synchronous on a rising edge with rst=1:
  - FIFO flushed, fifo_count=0.
  - State = IDLE, remaining counter = 0.
  - J=0, K=0, drv_valid=0, cmd_last=0, q_model=0.
  - Reset mid-command aborts it immediately; no cmd_last is issued for the aborted command.
- cmd_ready is combinational: !rst && (fifo_count != DEPTH).
  - Push occurs on an edge where cmd_valid && cmd_ready.
  - When the FIFO is full, no push is accepted even if a pop happens on the same edge.
  - Push and pop on the same edge with the FIFO not full: fifo_count unchanged.
- FIFO ordering: strict first-in first-out; pointers wrap modulo DEPTH.
- J, K, drv_valid and cmd_last are registered outputs.
- State IDLE:
  - J=K=0, drv_valid=0.
  - If the FIFO is non-empty at an edge: pop the head, load J,K=op and remaining=len, set drv_valid=1, go to DRIVE.
  - cmd_last=1 at that edge iff len=0.
  - Latency: a command pushed into an empty idle FIFO at edge N drives from edge N+1.
- State DRIVE:
  - If remaining>0: decrement remaining; J/K held; cmd_last=1 iff the new remaining value is 0.
  - If remaining=0 and the FIFO is non-empty: pop the next command with no bubble cycle (same load rules as IDLE), stay in DRIVE.
  - If remaining=0 and the FIFO is empty: J=K=0, drv_valid=0, cmd_last=0, go to IDLE.
- Every command therefore occupies exactly cmd_len+1 consecutive cycles with drv_valid=1.
- A push into an empty FIFO on the same edge that DRIVE ends does not get the no-bubble pop. The FIFO is sampled before the push, so the sequencer goes to IDLE and the command starts one edge later.
- q_model updates on every non-reset edge from the current registered J,K:
  - 00: hold.
  - 01: 0.
  - 10: 1.
  - 11: invert.
  - Result: q_model equals the downstream flop's Q in the same cycle, provided the flop shares clk and rst.
- cmd_len arithmetic is unsigned. cmd_len = 2^LEN_W-1 gives 2^LEN_W cycles, and the counter must not wrap.

Test Plan:
- Reset, then push op=10, len=0 → drv_valid high for exactly 1 cycle with J=1, K=0 and cmd_last=1 in that cycle. q_model=1 afterwards; J=K=0 after.
- Push op=11, len=3 → 4 cycles of J=K=1, cmd_last only on the 4th. q_model sequence from 0: 1,0,1,0; downstream Q matches every cycle.
- Push 4 commands back-to-back while the sequencer is busy → cmd_ready=0 once fifo_count=4. A 5th cmd_valid is not accepted until a pop; commands drive with zero idle cycles between them.
- Push op=01 len=1, op=10 len=2, op=00 len=0 → J/K sequence 01,01,10,10,10,00. cmd_last pulses at cycles 2, 5 and 6; q_model 0,0,1,1,1,1.
- Push op=11 len=15, assert rst for one cycle during the 6th drive cycle → the next cycle shows J=K=0, drv_valid=0, cmd_last never asserts, fifo_count=0, q_model=0. cmd_ready=0 while rst is high.
- Max length: op=10, len=15 → exactly 16 drive cycles, no counter wrap, then IDLE.
